icu_sequencer: RTL

- Program sequencer for the one-bit industrial control unit core; supplies the external program counter, jump/return stack and I/O address latch that the core needs.
- Fetches {opcode, operand} words from an external asynchronous-read program ROM and drives the core's 4-bit instruction input.
- Redirects the PC on JMP and RTN, and holds the I/O address for the core's read and write phases.
- Sits between program ROM, core and I/O selector; shares clock and reset with the core.

---
 rtl/icu_pkg.sv | 27 ++
 rtl/icu_ret_stack.sv | 49 ++++
 rtl/icu_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/icu_pkg.sv
// Shared definitions for the one-bit ICU core and its program sequencer.
// Opcode map and the two-phase instruction cycle encoding.
package icu_pkg;

    localparam logic [3:0] NOPO = 4'h0;
    localparam logic [3:0] LD   = 4'h1;
    localparam logic [3:0] LDC  = 4'h2;
    localparam logic [3:0] AND  = 4'h3;
    localparam logic [3:0] ANDC = 4'h4;
    localparam logic [3:0] OR   = 4'h5;
    localparam logic [3:0] ORC  = 4'h6;
    localparam logic [3:0] XNOR = 4'h7;
    localparam logic [3:0] STO  = 4'h8;
    localparam logic [3:0] STOC = 4'h9;
    localparam logic [3:0] IEN  = 4'hA;
    localparam logic [3:0] OEN  = 4'hB;
    localparam logic [3:0] JMP  = 4'hC;
    localparam logic [3:0] RTN  = 4'hD;
    localparam logic [3:0] SKZ  = 4'hE;
    localparam logic [3:0] NOPF = 4'hF;

    typedef enum logic {
        FETCH          = 1'b0,
        DECODE_EXECUTE = 1'b1
    } phase_e;

endpackage

// File: rtl/icu_ret_stack.sv
// Return-address LIFO for the ICU sequencer.
// Overflowing pushes and underflowing pops are ignored; the caller flags them.
module icu_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] cnt;
    logic [W-1:0]  mem [2**IW];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign wr_idx = IW'(cnt);
    assign rd_idx = IW'(cnt - CW'(1));
    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign dout   = mem[rd_idx];

    // Occupancy count; reset empties the stack without touching contents.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Entry storage; contents after reset are don't-care.
    always_ff @(posedge clk_in) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/icu_sequencer.sv
// Program sequencer for the one-bit ICU core: PC, return stack, I/O latch.
// Runs a fetch/execute phase in lockstep with the core and flags disagreement.
module icu_sequencer
    import icu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int IO_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    input  logic [IO_W+3:0]   rom_data,
    output logic [3:0]        icu_I,
    input  logic              icu_state,
    input  logic              icu_skp,
    input  logic              icu_jmp,
    input  logic              icu_rtn,
    input  logic              icu_write,
    output logic [IO_W-1:0]   io_addr,
    output logic              io_we,
    output logic              phase,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic              seq_err
);

    phase_e            phase_q;
    logic [3:0]        op_q;
    logic              skipped_q;
    logic              after_rtn;
    logic              jmp_done;
    logic              rtn_done;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] top;

    assign icu_I    = rom_data[IO_W+3:IO_W];
    assign io_we    = icu_write;
    assign phase    = phase_q;
    assign jmp_done = (op_q == JMP) && !skipped_q;
    assign rtn_done = (op_q == RTN) && !skipped_q;
    assign push     = (phase_q == DECODE_EXECUTE) && jmp_done;
    assign pop      = (phase_q == DECODE_EXECUTE) && rtn_done;

    icu_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk_in (clk_in),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (pc),
        .dout   (top),
        .full   (full),
        .empty  (empty)
    );

    // Phase machine: latch the instruction on fetch, redirect the PC on execute.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            phase_q   <= FETCH;
            pc        <= '0;
            io_addr   <= '0;
            op_q      <= NOPO;
            skipped_q <= 1'b0;
            after_rtn <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            phase_q <= (phase_q == FETCH) ? DECODE_EXECUTE : FETCH;
            if (icu_state != phase_q) begin
                seq_err <= 1'b1;
            end
            if (phase_q == FETCH) begin
                op_q      <= rom_data[IO_W+3:IO_W];
                io_addr   <= rom_data[IO_W-1:0];
                skipped_q <= icu_skp;
                after_rtn <= rtn_done;
                if (icu_jmp != jmp_done) begin
                    seq_err <= 1'b1;
                end
                if (icu_rtn && !rtn_done && !(skipped_q && after_rtn)) begin
                    seq_err <= 1'b1;
                end
            end else if (skipped_q) begin
                pc <= pc + ADDR_W'(1);
            end else if (op_q == JMP) begin
                pc <= io_addr[ADDR_W-1:0];
                if (full) begin
                    stack_ovf <= 1'b1;
                end
            end else if (op_q == RTN) begin
                pc <= empty ? '0 : top;
                if (empty) begin
                    stack_unf <= 1'b1;
                end
            end else begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

endmodule
